// File: rtl/mac_tx_arb.sv
// Packet-granular round-robin arbiter feeding the 8-bit MAC transmit stream.
// Locks onto one requester per frame, zero-pads runts and inserts the inter-frame gap.
module mac_tx_arb #(
    parameter int NUM_REQ    = 2,
    parameter int MIN_BYTES  = 60,
    parameter int IFG_CYCLES = 12
) (
    input  logic                   mac_clk,
    input  logic                   mac_rst_n,
    input  logic [NUM_REQ-1:0]     in_valid,
    output logic [NUM_REQ-1:0]     in_ready,
    input  logic [NUM_REQ-1:0]     in_startofpacket,
    input  logic [NUM_REQ-1:0]     in_endofpacket,
    input  logic [NUM_REQ-1:0]     in_error,
    input  logic [8*NUM_REQ-1:0]   in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_startofpacket,
    output logic                   out_endofpacket,
    output logic                   out_error,
    output logic [7:0]             out_data,
    output logic [NUM_REQ-1:0]     grant,
    output logic                   busy
);

    localparam int RW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW       = $clog2(MIN_BYTES + 1);
    localparam int IW       = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
    localparam int IFG_LAST = (IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0;

    typedef enum logic [1:0] {S_IDLE, S_PACKET, S_PAD, S_IFG} state_t;

    state_t             state, state_nxt;
    logic [RW-1:0]      rr, gidx, win;
    logic               win_vld;
    logic [CW-1:0]      cnt;
    logic [CW:0]        cnt_inc;
    logic [IW-1:0]      ifg_cnt;
    logic               first;
    logic               at_min;
    logic               xfer;
    logic               frame_done;
    logic [NUM_REQ-1:0] cand;

    assign cand    = in_valid & in_startofpacket;
    assign cnt_inc = {1'b0, cnt} + 1'b1;
    assign at_min  = (cnt_inc >= (CW+1)'(MIN_BYTES));
    assign xfer    = out_valid & out_ready;
    assign busy    = (state != S_IDLE);

    // Scan from the lowest priority offset down so the nearest candidate to rr wins.
    always_comb begin
        int idx;
        win     = '0;
        win_vld = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(rr) + k) % NUM_REQ;
            if (cand[idx]) begin
                win     = RW'(idx);
                win_vld = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt         = state;
        out_valid         = 1'b0;
        out_startofpacket = 1'b0;
        out_endofpacket   = 1'b0;
        out_error         = 1'b0;
        out_data          = 8'h00;
        in_ready          = '0;
        frame_done        = 1'b0;
        case (state)
            S_IDLE: begin
                // Beats without sop cannot start a frame; swallow them here.
                in_ready = in_valid & ~in_startofpacket;
                if (win_vld) state_nxt = S_PACKET;
            end
            S_PACKET: begin
                out_valid         = in_valid[gidx];
                out_data          = in_data[{gidx, 3'b000} +: 8];
                out_startofpacket = in_startofpacket[gidx] & first;
                out_error         = in_error[gidx] | (in_startofpacket[gidx] & ~first);
                out_endofpacket   = in_endofpacket[gidx] & at_min;
                in_ready[gidx]    = out_ready;
                if (xfer && in_endofpacket[gidx]) begin
                    if (at_min) frame_done = 1'b1;
                    else        state_nxt  = S_PAD;
                end
            end
            S_PAD: begin
                out_valid       = 1'b1;
                out_endofpacket = at_min;
                if (xfer && at_min) frame_done = 1'b1;
            end
            S_IFG: begin
                if (ifg_cnt == IW'(IFG_LAST)) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (frame_done) state_nxt = (IFG_CYCLES == 0) ? S_IDLE : S_IFG;
    end

    always_ff @(posedge mac_clk or negedge mac_rst_n) begin
        if (!mac_rst_n) begin
            state   <= S_IDLE;
            grant   <= '0;
            gidx    <= '0;
            rr      <= '0;
            cnt     <= '0;
            ifg_cnt <= '0;
            first   <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (win_vld) begin
                        gidx  <= win;
                        grant <= NUM_REQ'(1) << win;
                        cnt   <= '0;
                        first <= 1'b1;
                    end
                end
                S_PACKET, S_PAD: begin
                    if (xfer) begin
                        first <= 1'b0;
                        cnt   <= at_min ? CW'(MIN_BYTES) : cnt_inc[CW-1:0];
                    end
                end
                S_IFG:   ifg_cnt <= ifg_cnt + 1'b1;
                default: ;
            endcase
            if (frame_done) begin
                grant   <= '0;
                rr      <= (gidx == RW'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
                ifg_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mac_tx_arb.sv
// Randomized bench for mac_tx_arb: per-requester source queues and expected padded frames.
module tb_mac_tx_arb;

    localparam int NR   = 2;
    localparam int MINB = 60;
    localparam int IFG  = 12;

    typedef struct packed {
        logic       sop;
        logic       eop;
        logic       err;
        logic [7:0] data;
    } beat_t;

    logic              mac_clk = 1'b0;
    logic              mac_rst_n;
    logic [NR-1:0]     in_valid, in_ready, in_startofpacket, in_endofpacket, in_error;
    logic [8*NR-1:0]   in_data;
    logic              out_valid, out_ready, out_startofpacket, out_endofpacket, out_error;
    logic [7:0]        out_data;
    logic [NR-1:0]     grant;
    logic              busy;

    always #5 mac_clk = ~mac_clk;

    mac_tx_arb #(.NUM_REQ(NR), .MIN_BYTES(MINB), .IFG_CYCLES(IFG)) dut (
        .mac_clk(mac_clk), .mac_rst_n(mac_rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_startofpacket(in_startofpacket), .in_endofpacket(in_endofpacket),
        .in_error(in_error), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_startofpacket(out_startofpacket), .out_endofpacket(out_endofpacket),
        .out_error(out_error), .out_data(out_data),
        .grant(grant), .busy(busy)
    );

    beat_t         src_q[NR][$];
    beat_t         exp_q[NR][$];
    int            gseq[$];
    logic [NR-1:0] vld;
    int            checks = 0, errors = 0, cyc = 0, out_cnt = 0;
    int            p_valid = 100, p_ready = 100, rdy_low = 0;
    int            last_eop_cyc = -1, last_gap = -1;
    logic          prev_stall = 1'b0;
    logic [11:0]   prev_out = '0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Expected output: first beat keeps sop, later sop beats become errors, runts pad to MINB.
    task automatic add_frame(input int r, input int len, input int err_pos, input int sop_pos, input bit incr);
        beat_t b, e;
        for (int i = 0; i < len; i++) begin
            b.sop  = (i == 0) || (i == sop_pos);
            b.eop  = (i == len - 1);
            b.err  = (i == err_pos);
            b.data = incr ? 8'(i) : 8'($urandom);
            src_q[r].push_back(b);
            e.sop  = (i == 0);
            e.eop  = (i == len - 1) && (len >= MINB);
            e.err  = b.err | (b.sop && i > 0);
            e.data = b.data;
            exp_q[r].push_back(e);
        end
        for (int i = len; i < MINB; i++) begin
            e = '{sop: 1'b0, eop: (i == MINB - 1), err: 1'b0, data: 8'h00};
            exp_q[r].push_back(e);
        end
    endtask

    task automatic add_orphans(input int r, input int n);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b = '{sop: 1'b0, eop: 1'($urandom), err: 1'($urandom), data: 8'($urandom)};
            src_q[r].push_back(b);
        end
    endtask

    task automatic drive();
        beat_t h;
        for (int i = 0; i < NR; i++) begin
            h = vld[i] ? src_q[i][0] : '0;
            in_valid[i]         = vld[i];
            in_startofpacket[i] = h.sop;
            in_endofpacket[i]   = h.eop;
            in_error[i]         = h.err;
            in_data[8*i +: 8]   = h.data;
        end
    endtask

    task automatic monitor();
        logic [11:0] cur;
        beat_t       e;
        int          g;
        cur = {out_valid, out_startofpacket, out_endofpacket, out_error, out_data};
        if (prev_stall) chk("stall_hold", cur, prev_out);
        prev_stall = out_valid && !out_ready;
        prev_out   = cur;
        if (|grant && !out_ready) chk("stall_no_accept", in_ready, 0);
        if (out_valid && out_ready) begin
            g = -1;
            for (int i = 0; i < NR; i++) if (grant[i]) g = i;
            chk("grant_onehot", $countones(grant), 1);
            if (out_startofpacket) begin
                gseq.push_back(g);
                if (last_eop_cyc >= 0) begin
                    last_gap = cyc - last_eop_cyc;
                    chk("ifg_min", (last_gap >= IFG + 2) ? 1 : 0, 1);
                end
            end
            if (g < 0 || exp_q[g].size() == 0) chk("exp_avail", 0, 1);
            else begin
                e = exp_q[g].pop_front();
                chk("beat", {out_startofpacket, out_endofpacket, out_error, out_data}, e);
            end
            if (out_endofpacket) last_eop_cyc = cyc;
            out_cnt++;
        end
    endtask

    task automatic tick();
        logic [NR-1:0] acc;
        @(negedge mac_clk);
        for (int i = 0; i < NR; i++)
            if (!vld[i] && src_q[i].size() > 0 && $urandom_range(99) < p_valid) vld[i] = 1'b1;
        drive();
        if (rdy_low > 0) begin out_ready = 1'b0; rdy_low--; end
        else out_ready = ($urandom_range(99) < p_ready);
        #1;
        monitor();
        acc = in_valid & in_ready;
        @(posedge mac_clk);
        cyc++;
        for (int i = 0; i < NR; i++)
            if (acc[i]) begin void'(src_q[i].pop_front()); vld[i] = 1'b0; end
    endtask

    function automatic int pending();
        int n = 0;
        for (int i = 0; i < NR; i++) n += src_q[i].size() + exp_q[i].size();
        return n;
    endfunction

    task automatic drain();
        int b = 0;
        while (pending() != 0 && b < 20000) begin tick(); b++; end
        chk("drain", pending(), 0);
        repeat (IFG + 3) tick();
    endtask

    task automatic run_until(input int n);
        int b = 0;
        while (out_cnt < n && b < 2000) begin tick(); b++; end
        chk("run_until", (out_cnt >= n) ? 1 : 0, 1);
    endtask

    task automatic clear_model();
        for (int i = 0; i < NR; i++) begin src_q[i].delete(); exp_q[i].delete(); end
        vld = '0;
        drive();
        out_ready    = 1'b1;
        rdy_low      = 0;
        prev_stall   = 1'b0;
        last_eop_cyc = -1;
        gseq.delete();
    endtask

    initial begin
        int base;
        mac_rst_n = 1'b1;
        vld       = '0;
        drive();
        out_ready = 1'b0;
        #1 mac_rst_n = 1'b0;
        repeat (3) @(posedge mac_clk);
        #1;
        chk("rst_outs", {out_valid, out_startofpacket, out_endofpacket, out_error,
                         out_data, in_ready, grant, busy}, 0);
        @(negedge mac_clk);
        mac_rst_n = 1'b1;

        // Both requesters contend right after reset: order 0,1,0.
        add_frame(0, 64, -1, -1, 0);
        add_frame(0, 64, -1, -1, 0);
        add_frame(1, 64, -1, -1, 0);
        drain();
        chk("rr_cnt", gseq.size(), 3);
        chk("rr_0", (gseq.size() > 0) ? gseq[0] : -1, 0);
        chk("rr_1", (gseq.size() > 1) ? gseq[1] : -1, 1);
        chk("rr_2", (gseq.size() > 2) ? gseq[2] : -1, 0);

        // Back-to-back 64-byte incrementing frames: exact gap eop -> next sop.
        add_frame(0, 64, -1, -1, 1);
        add_frame(0, 64, -1, -1, 1);
        drain();
        chk("ifg_exact", last_gap, IFG + 2);

        // Runt with error on byte 3, padded to MINB.
        base = out_cnt;
        add_frame(1, 10, 3, -1, 1);
        drain();
        chk("runt_len", out_cnt - base, MINB);

        // Stalls mid-frame and during padding.
        base = out_cnt;
        add_frame(0, 64, -1, -1, 1);
        add_frame(0, 10, -1, -1, 1);
        run_until(base + 10);  rdy_low = 5;
        run_until(base + 80);  rdy_low = 3;
        run_until(base + 100); rdy_low = 2;
        drain();
        chk("stall_len", out_cnt - base, 64 + MINB);

        // Orphan beats while idle are flushed, then a real frame.
        base = out_cnt;
        add_orphans(1, 3);
        repeat (6) tick();
        chk("orphan_no_out", out_cnt, base);
        chk("orphan_flushed", src_q[1].size(), 0);
        add_frame(1, 20, -1, -1, 1);
        drain();
        chk("orphan_frame_len", out_cnt - base, MINB);

        // Randomized traffic with gaps, backpressure, errors, stray sops and orphans.
        p_valid = 60;
        p_ready = 70;
        for (int f = 0; f < 24; f++) begin
            int r, len, ep, sp;
            r   = $urandom_range(NR - 1);
            len = $urandom_range(90, 1);
            ep  = ($urandom_range(9) == 0) ? $urandom_range(len - 1) : -1;
            sp  = (len > 1 && $urandom_range(7) == 0) ? $urandom_range(len - 1, 1) : -1;
            if ($urandom_range(5) == 0) add_orphans(r, $urandom_range(3, 1));
            add_frame(r, len, ep, sp, 0);
        end
        drain();

        // Reset in the middle of a frame, then contention resolves to requester 0.
        p_valid = 100;
        p_ready = 100;
        add_frame(0, 64, -1, -1, 1);
        base = out_cnt;
        run_until(base + 20);
        #2 mac_rst_n = 1'b0;
        #1;
        chk("rst_mid", {out_valid, out_endofpacket, grant, busy}, 0);
        clear_model();
        repeat (2) @(posedge mac_clk);
        @(negedge mac_clk);
        mac_rst_n = 1'b1;
        add_frame(0, 30, -1, -1, 0);
        add_frame(1, 30, -1, -1, 0);
        drain();
        chk("post_rst_cnt", gseq.size(), 2);
        chk("post_rst_first", (gseq.size() > 0) ? gseq[0] : -1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
